// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Imported by the hazard detector and the stall/flush controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IWAIT = 2'd1,
      DWAIT = 2'd2
   } hz_state_t;

   // Register $zero never carries a real dependency.
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the instruction in ID.
// Holds no state.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_branch,
   input  logic [REG_W-1:0] ex_wreg,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] mem_wreg,
   input  logic             mem_memread,
   output logic             lu,
   output logic             bs
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = (ex_wreg  != REG_W'(REG_ZERO)) && ((ex_wreg  == id_rs) || (ex_wreg  == id_rt));
   assign mem_hit = (mem_wreg != REG_W'(REG_ZERO)) && ((mem_wreg == id_rs) || (mem_wreg == id_rt));

   assign lu = ex_memread & ex_hit;
   // A branch resolving in ID needs ALU results from EX and load data from MEM.
   assign bs = id_branch & ((ex_regwrite & ex_hit) | (mem_memread & mem_hit));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: drives PC, IF/ID and ID/EX enables and clears,
// holds branch redirects that arrive while fetch is frozen, and counts stall/flush cycles.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Ihit,
   input  logic             Dhit,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_branch,
   input  logic             id_redirect,
   input  logic [31:0]      id_target,
   input  logic [REG_W-1:0] ex_wreg,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] mem_wreg,
   input  logic             mem_memread,
   output logic             pc_en,
   output logic             dec_en,
   output logic             dec_clr,
   output logic             ex_en,
   output logic             ex_clr,
   output logic             redir_valid,
   output logic [31:0]      redir_target,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_t        state_q, state_d;
   logic             redir_valid_q, redir_valid_d;
   logic [31:0]      redir_target_q, redir_target_d;
   logic             flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lu, bs, stall_hz, redir_set;

   hazard_detect #(.REG_W(REG_W)) u_detect (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_branch   (id_branch),
      .ex_wreg     (ex_wreg),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .mem_wreg    (mem_wreg),
      .mem_memread (mem_memread),
      .lu          (lu),
      .bs          (bs)
   );

   assign stall_hz = lu | bs;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      unique case (state_q)
         RUN, IWAIT, DWAIT: begin
            if (!Dhit)      state_d = DWAIT;
            else if (!Ihit) state_d = IWAIT;
            else            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      pc_en   = 1'b1;
      dec_en  = 1'b1;
      dec_clr = 1'b0;
      ex_en   = 1'b1;
      ex_clr  = 1'b0;
      if (!Dhit) begin
         pc_en  = 1'b0;
         dec_en = 1'b0;
         ex_en  = 1'b0;
      end else if (!Ihit) begin
         pc_en   = 1'b0;
         dec_clr = 1'b1;
      end else if (stall_hz) begin
         pc_en  = 1'b0;
         dec_en = 1'b0;
         ex_clr = 1'b1;
      end else if (id_redirect) begin
         dec_clr = 1'b1;
      end
      // A redirect captured while IF/ID was frozen still owes one squash of the wrong-path fetch.
      if (flush_pend_q && dec_en) dec_clr = 1'b1;
   end

   always_comb begin
      redir_set      = id_redirect && !pc_en && !stall_hz;
      redir_valid_d  = redir_valid_q;
      redir_target_d = redir_target_q;
      flush_pend_d   = flush_pend_q;
      if (pc_en)          redir_valid_d = 1'b0;
      else if (redir_set) redir_valid_d = 1'b1;
      if (redir_set) redir_target_d = id_target;
      if (redir_set && !dec_en) flush_pend_d = 1'b1;
      else if (dec_en)          flush_pend_d = 1'b0;

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en && (stall_cnt_q != '1))               stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (dec_en && dec_clr && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= RUN;
         redir_valid_q  <= 1'b0;
         redir_target_q <= '0;
         flush_pend_q   <= 1'b0;
         stall_cnt_q    <= '0;
         flush_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         redir_valid_q  <= redir_valid_d;
         redir_target_q <= redir_target_d;
         flush_pend_q   <= flush_pend_d;
         stall_cnt_q    <= stall_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign redir_valid  = redir_valid_q;
   assign redir_target = redir_target_q;
   assign stall_cnt    = stall_cnt_q;
   assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl: cache misses, load-use and branch stalls,
// redirect hold, counter saturation and asynchronous reset.
module tb_pipeline_hazard_ctrl;
   import pipe_pkg::*;

   localparam int CNT_W = 32;
   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             Ihit, Dhit;
   logic [REG_W-1:0] id_rs, id_rt, ex_wreg, mem_wreg;
   logic             id_branch, id_redirect, ex_regwrite, ex_memread, mem_memread;
   logic [31:0]      id_target;
   logic             pc_en, dec_en, dec_clr, ex_en, ex_clr, redir_valid;
   logic [31:0]      redir_target;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int               n_vec = 0;
   int               n_err = 0;
   logic [CNT_W-1:0] exp_stall = '0;
   logic [CNT_W-1:0] exp_flush = '0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .Ihit         (Ihit),
      .Dhit         (Dhit),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_branch    (id_branch),
      .id_redirect  (id_redirect),
      .id_target    (id_target),
      .ex_wreg      (ex_wreg),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .mem_wreg     (mem_wreg),
      .mem_memread  (mem_memread),
      .pc_en        (pc_en),
      .dec_en       (dec_en),
      .dec_clr      (dec_clr),
      .ex_en        (ex_en),
      .ex_clr       (ex_clr),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are already applied at a falling edge; check the Mealy outputs mid-cycle,
   // account the expected counter steps, then ride through the rising edge.
   task automatic cycle(input string tag, input logic e_pc, input logic e_dec, input logic e_dclr,
                        input logic e_ex, input logic e_xclr);
      #2;
      check({tag, ".pc_en"},   pc_en,   e_pc);
      check({tag, ".dec_en"},  dec_en,  e_dec);
      check({tag, ".dec_clr"}, dec_clr, e_dclr);
      check({tag, ".ex_en"},   ex_en,   e_ex);
      check({tag, ".ex_clr"},  ex_clr,  e_xclr);
      if (!e_pc && exp_stall != '1)           exp_stall = exp_stall + 1;
      if (e_dec && e_dclr && exp_flush != '1) exp_flush = exp_flush + 1;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      Ihit = 1'b1; Dhit = 1'b1;
      id_rs = '0; id_rt = '0; id_branch = 1'b0; id_redirect = 1'b0; id_target = '0;
      ex_wreg = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_wreg = '0; mem_memread = 1'b0;
   endtask

   task automatic check_counters(input string tag);
      check({tag, ".stall_cnt"}, stall_cnt, exp_stall);
      check({tag, ".flush_cnt"}, flush_cnt, exp_flush);
   endtask

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      #2;
      check("rst.state",        dut.state_q,  RUN);
      check("rst.pc_en",        pc_en,        1'b1);
      check("rst.dec_clr",      dec_clr,      1'b0);
      check("rst.redir_valid",  redir_valid,  1'b0);
      check("rst.redir_target", redir_target, 32'h0);
      check("rst.stall_cnt",    stall_cnt,    32'd0);
      check("rst.flush_cnt",    flush_cnt,    32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle("idle", 1, 1, 0, 1, 0);

      // I-cache miss for three cycles: bubbles into ID, front end frozen.
      Ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle("imiss", 0, 1, 1, 1, 0);
         check("imiss.state", dut.state_q, IWAIT);
      end
      Ihit = 1'b1;
      cycle("imiss_done", 1, 1, 0, 1, 0);
      check("imiss_done.state", dut.state_q, RUN);
      check("imiss.stall_cnt3", stall_cnt, 32'd3);
      check("imiss.flush_cnt3", flush_cnt, 32'd3);

      // Load-use on rs, then on rt; register zero never stalls.
      ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8;
      cycle("lu_rs", 0, 0, 0, 1, 1);
      ex_memread = 1'b0;
      cycle("lu_gone", 1, 1, 0, 1, 0);
      ex_memread = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0;
      cycle("lu_zero", 1, 1, 0, 1, 0);
      ex_wreg = 5'd8; id_rt = 5'd8;
      cycle("lu_rt", 0, 0, 0, 1, 1);
      idle_inputs();

      // Branch operand from EX; the redirect raised in the same cycle must be ignored.
      id_branch = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9;
      id_redirect = 1'b1; id_target = 32'h0000_dead;
      cycle("bs_ex", 0, 0, 0, 1, 1);
      check("bs_ex.redir_valid", redir_valid, 1'b0);
      idle_inputs();
      id_branch = 1'b1; mem_memread = 1'b1; mem_wreg = 5'd3; id_rs = 5'd3;
      cycle("bs_mem", 0, 0, 0, 1, 1);
      id_branch = 1'b0;
      cycle("no_branch", 1, 1, 0, 1, 0);
      idle_inputs();
      check_counters("stalls");

      // Redirect with no stall just squashes the fetch; nothing is held.
      id_redirect = 1'b1; id_target = 32'h0040_0000;
      cycle("redir_run", 1, 1, 1, 1, 0);
      check("redir_run.valid", redir_valid, 1'b0);

      // Redirect during an I-miss is held until the PC next advances.
      Ihit = 1'b0; id_target = 32'h0040_0100;
      cycle("redir_im", 0, 1, 1, 1, 0);
      check("redir_im.valid",  redir_valid,  1'b1);
      check("redir_im.target", redir_target, 32'h0040_0100);
      id_redirect = 1'b0; id_target = '0;
      cycle("redir_hold", 0, 1, 1, 1, 0);
      check("redir_hold.valid", redir_valid, 1'b1);
      Ihit = 1'b1;
      #1;
      check("redir_load.valid",  redir_valid,  1'b1);
      check("redir_load.target", redir_target, 32'h0040_0100);
      cycle("redir_load", 1, 1, 0, 1, 0);
      check("redir_done.valid", redir_valid, 1'b0);

      // A second held redirect overwrites the first.
      Ihit = 1'b0; id_redirect = 1'b1; id_target = 32'h0040_0200;
      cycle("ovw_a", 0, 1, 1, 1, 0);
      id_target = 32'h0040_0300;
      cycle("ovw_b", 0, 1, 1, 1, 0);
      check("ovw.target", redir_target, 32'h0040_0300);
      Ihit = 1'b1; id_redirect = 1'b0;
      cycle("ovw_load", 1, 1, 0, 1, 0);
      check("ovw_done.valid", redir_valid, 1'b0);

      // Redirect during a D-miss: IF/ID frozen, so the squash is deferred one cycle.
      Dhit = 1'b0; id_redirect = 1'b1; id_target = 32'h0040_0400;
      cycle("redir_dm", 0, 0, 0, 0, 0);
      check("redir_dm.valid", redir_valid, 1'b1);
      check("redir_dm.state", dut.state_q, DWAIT);
      Dhit = 1'b1; id_redirect = 1'b0;
      cycle("flush_pend", 1, 1, 1, 1, 0);
      cycle("after_pend", 1, 1, 0, 1, 0);
      check("after_pend.valid", redir_valid, 1'b0);

      // Simultaneous misses: DWAIT wins, then IWAIT once data returns.
      Dhit = 1'b0; Ihit = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cycle("both_miss", 0, 0, 0, 0, 0);
         check("both_miss.state", dut.state_q, DWAIT);
      end
      Dhit = 1'b1;
      cycle("d_back", 0, 1, 1, 1, 0);
      check("d_back.state", dut.state_q, IWAIT);
      Ihit = 1'b1;
      cycle("i_back", 1, 1, 0, 1, 0);
      check("i_back.state", dut.state_q, RUN);
      check_counters("misses");

      // Saturation: preload all-ones, one more stall must not wrap.
      force dut.stall_cnt_q = {CNT_W{1'b1}};
      #1;
      release dut.stall_cnt_q;
      exp_stall = '1;
      Ihit = 1'b0;
      cycle("sat", 0, 1, 1, 1, 0);
      Ihit = 1'b1;
      check("sat.stall_cnt", stall_cnt, 32'hFFFF_FFFF);

      // Asynchronous reset in the middle of a D-miss with a held redirect.
      Dhit = 1'b0; id_redirect = 1'b1; id_target = 32'h0040_0500;
      cycle("pre_rst", 0, 0, 0, 0, 0);
      check("pre_rst.valid", redir_valid, 1'b1);
      id_redirect = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst.state",      dut.state_q,      RUN);
      check("mid_rst.valid",      redir_valid,      1'b0);
      check("mid_rst.target",     redir_target,     32'h0);
      check("mid_rst.flush_pend", dut.flush_pend_q, 1'b0);
      check("mid_rst.stall_cnt",  stall_cnt,        32'd0);
      check("mid_rst.flush_cnt",  flush_cnt,        32'd0);
      exp_stall = '0;
      exp_flush = '0;
      Dhit = 1'b1;
      #1;
      check("mid_rst.pc_en",   pc_en,   1'b1);
      check("mid_rst.dec_clr", dec_clr, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      cycle("post_rst", 1, 1, 0, 1, 0);
      check_counters("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
